rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_pkg.sv | 20 ++
 rtl/rom_arbiter_rr_picker.sv | 42 ++++
 rtl/rom_arbiter.sv | 129 ++++++++++++
 tb/tb_rom_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the ROM burst arbiter.
// Burst lengths use a 4-bit field where 0 means 16 words.
package rom_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int LEN_W = 4;
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(1 << LEN_W);

  function automatic logic [LEN_W:0] burst_len(
    input logic [LEN_W-1:0] f
  );
    return (f == '0) ? MAX_LEN : {1'b0, f};
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_picker.sv
// Round-robin winner pick over the request vector.
// The pointer names the highest-priority requester.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            take,
  output logic            any,
  output logic [ID_W-1:0] win
);

  logic [ID_W-1:0] ptr_q;
  int idx;

  // first active request at or after the pointer, wrapping
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = ID_W'(idx);
      end
    end
  end

  // after a grant, the requester just past the winner leads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (take) begin
      ptr_q <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one ROM port among NREQ burst requesters.
// Grants round-robin and streams each burst back in order.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*4-1:0]        req_len,
  output logic [NREQ-1:0]          gnt,
  output logic                     rom_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(NREQ)-1:0]  rd_id,
  output logic                     rd_last,
  output logic                     busy
);

  localparam int ID_W = $clog2(NREQ);

  state_t state_q, state_d;

  logic            any;
  logic [ID_W-1:0] win;
  logic            take;
  logic            issue;
  logic            at_end;

  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W:0]    len_q;
  logic [LEN_W:0]    cnt_q;
  logic [ID_W-1:0]   own_q;
  logic [NREQ-1:0]   gnt_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic [ID_W-1:0]   rd_id_q;

  assign issue  = (state_q == ISSUE);
  assign take   = (state_q == IDLE) && any;
  assign at_end = (cnt_q == len_q - 1'b1);

  rr_picker #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .take  (take),
    .any   (any),
    .win   (win)
  );

  // route the winner's address and length fields
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == win) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state: one burst, one drain cycle, back to idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any) state_d = ISSUE;
      ISSUE:   if (at_end) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // burst bookkeeping and the return pipeline stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      own_q      <= '0;
      gnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      gnt_q      <= '0;
      rd_valid_q <= issue;
      rd_id_q    <= issue ? own_q : '0;
      rd_last_q  <= issue && at_end;
      if (take) begin
        gnt_q  <= NREQ'(1) << win;
        base_q <= sel_addr;
        len_q  <= burst_len(sel_len);
        own_q  <= win;
        cnt_q  <= '0;
      end else if (issue) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign gnt      = gnt_q;
  assign rom_en   = issue;
  assign rom_addr = issue ? base_q + ADDR_W'(cnt_q) : '0;
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_last  = rd_last_q;
  assign rd_data  = rom_data;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: timeline model of expected outputs,
// directed scenarios with literal expectations, random traffic.
module tb_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int D  = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*4-1:0]  req_len = '0;
  logic [N-1:0]    gnt;
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic [1:0]      rd_id;
  logic            rd_last;
  logic            busy;

  always #5 clk = ~clk;

  rom_arbiter #(
    .NREQ   (N),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_len  (req_len),
    .gnt      (gnt),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_id    (rd_id),
    .rd_last  (rd_last),
    .busy     (busy)
  );

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    return {a, ~a, a ^ 8'h5A, a + 8'd3};
  endfunction

  always @(posedge clk) rom_data <= romf(rom_addr);

  int tests = 0;
  int fails = 0;

  // ---------------- timeline model ----------------
  int cyc = 0;
  int idle_from = 0;
  int mptr = 0;
  logic [N-1:0]  e_gnt  [D];
  logic          e_en   [D];
  logic [AW-1:0] e_addr [D];
  logic          e_rv   [D];
  logic [1:0]    e_id   [D];
  logic          e_last [D];
  logic          e_busy [D];
  logic [DW-1:0] e_data [D];

  task automatic clr_slot(input int s);
    e_gnt[s] = '0; e_en[s] = 1'b0; e_addr[s] = '0;
    e_rv[s] = 1'b0; e_id[s] = '0; e_last[s] = 1'b0;
    e_busy[s] = 1'b0; e_data[s] = '0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < D; s++) clr_slot(s);
    idle_from = 0;
    mptr = 0;
  endtask

  initial model_reset();
  always @(negedge reset) model_reset();

  // on each edge: if the ending cycle was idle and someone asks,
  // lay out the whole burst on the timeline
  always @(posedge clk) begin
    int ending, w, len, s;
    logic [AW-1:0] b;
    ending = cyc;
    cyc = cyc + 1;
    if (reset && ending >= idle_from && req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(mptr + k) % N]) w = (mptr + k) % N;
      mptr = (w + 1) % N;
      b = req_addr[w*AW +: AW];
      len = int'(req_len[w*4 +: 4]);
      if (len == 0) len = 16;
      e_gnt[cyc % D] = N'(1) << w;
      for (int k = 0; k < len; k++) begin
        s = (cyc + k) % D;
        e_en[s] = 1'b1;
        e_addr[s] = b + AW'(k);
        e_busy[s] = 1'b1;
        s = (cyc + k + 1) % D;
        e_rv[s] = 1'b1;
        e_id[s] = 2'(w);
        e_last[s] = (k == len - 1);
        e_data[s] = romf(b + AW'(k));
        e_busy[s] = 1'b1;
      end
      idle_from = cyc + len + 1;
    end
  end

  // compare every cycle against the timeline
  always @(negedge clk) begin
    int s;
    logic [17:0] act, exp;
    s = cyc % D;
    act = {gnt, rom_en, rom_addr, rd_valid, rd_id, rd_last, busy};
    exp = {e_gnt[s], e_en[s], e_addr[s], e_rv[s], e_id[s],
           e_last[s], e_busy[s]};
    tests++;
    if (act !== exp || (e_rv[s] && rd_data !== e_data[s])) begin
      fails++;
      $display("FAIL cycle%0d: got %h data %h want %h data %h",
               cyc, act, rd_data, exp, e_data[s]);
    end
    clr_slot(s);
  end

  // ---------------- observation logs ----------------
  int gl[$];
  int gc[$];
  logic [AW-1:0] al[$];
  int rvcnt = 0;
  int lastpos = 0;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (gnt[i]) begin
        gl.push_back(i);
        gc.push_back(cyc);
      end
    if (rom_en) al.push_back(rom_addr);
    if (rd_valid) begin
      rvcnt++;
      if (rd_last) lastpos = rvcnt;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [7:0] a,
                         input logic [3:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*4 +: 4] = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    ticks(2);
    #2 reset = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 chk("reset_outs",
           {gnt, rom_en, rom_addr, rd_valid, rd_id, rd_last, busy}, 0);
    ticks(2);
    #2 reset = 1'b1;

    // single short burst from requester 2
    @(negedge clk);
    set_req(2, 8'h10, 4'd3);
    req = 4'b0100;
    @(negedge clk);
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_addr", rom_addr, 8'h10);
    chk("t1_busy", busy, 1);
    req = '0;
    @(negedge clk);
    chk("t2_addr", rom_addr, 8'h11);
    chk("t2_valid", {rd_valid, rd_id}, 3'b110);
    @(negedge clk);
    chk("t3_addr", rom_addr, 8'h12);
    chk("t3_gnt", gnt, 0);
    @(negedge clk);
    chk("t4_last", {rd_last, rom_en}, 2'b10);
    chk("t4_data", rd_data, romf(8'h12));
    @(negedge clk);
    chk("t5_idle", {busy, rd_valid}, 0);

    // all four at once, one word each
    do_reset();
    gl.delete(); gc.delete();
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h20 + i), 4'd1);
    req = 4'hF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req = req & ~gnt;
    end
    chk("rr_count", gl.size(), 4);
    if (gl.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("rr_order", gl[i], i);
        if (i > 0) chk("rr_gap", gc[i] - gc[i-1], 3);
      end

    // address wraps past the top of the ROM
    al.delete();
    set_req(1, 8'hFE, 4'd4);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    ticks(8);
    chk("wrap_n", al.size(), 4);
    if (al.size() == 4) begin
      chk("wrap0", al[0], 8'hFE);
      chk("wrap1", al[1], 8'hFF);
      chk("wrap2", al[2], 8'h00);
      chk("wrap3", al[3], 8'h01);
    end

    // length field 0 means sixteen words
    rvcnt = 0; lastpos = 0;
    set_req(0, 8'h40, 4'd0);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    ticks(20);
    chk("len16_words", rvcnt, 16);
    chk("len16_last", lastpos, 16);

    // reset during the third word of an eight-word burst
    set_req(2, 8'h80, 4'd8);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    ticks(3);
    chk("mid_word3", rd_valid, 1);
    #2 reset = 1'b0;
    #1 chk("mid_reset_outs",
           {gnt, rom_en, rom_addr, rd_valid, rd_id, rd_last, busy}, 0);
    rvcnt = 0;
    ticks(2);
    #2 reset = 1'b1;
    ticks(5);
    chk("mid_no_rv", rvcnt, 0);
    gl.delete();
    set_req(0, 8'h00, 4'd2);
    set_req(3, 8'h08, 4'd2);
    req = 4'b1001;
    @(negedge clk);
    req = '0;
    ticks(6);
    chk("mid_prio0", gl.size() > 0 ? gl[0] : -1, 0);

    // held req[3] must yield to req[1] raised during its burst
    gl.delete();
    set_req(3, 8'h30, 4'd4);
    set_req(1, 8'h50, 4'd2);
    req = 4'b1000;
    ticks(2);
    req[1] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (gnt[1]) req[1] = 1'b0;
    end
    req = '0;
    ticks(8);
    chk("fair_n", gl.size() >= 3, 1);
    if (gl.size() >= 3) begin
      chk("fair0", gl[0], 3);
      chk("fair1", gl[1], 1);
      chk("fair2", gl[2], 3);
    end

    // random traffic against the timeline model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      set_req($urandom_range(0, 3), 8'($urandom), 4'($urandom));
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        ticks($urandom_range(1, 3));
        #2 reset = 1'b1;
      end
    end
    req = '0;
    ticks(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
